// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared requester ids, arbiter state type and weight address map
// Purpose : common definitions imported by the weight memory port arbiter.
// Contents: req_idx_e    requester index (conv1, conv2, fc1, fc2)
//           arb_state_e  arbiter state (idle / locked to an owner)
//           *_W_BASE     flat weight/bias memory base address per layer
package cnn_pkg;

   typedef enum logic [1:0] {
      REQ_CONV1 = 2'd0,
      REQ_CONV2 = 2'd1,
      REQ_FC1   = 2'd2,
      REQ_FC2   = 2'd3
   } req_idx_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam logic [17:0] CONV1_W_BASE = 18'h00000;
   localparam logic [17:0] CONV2_W_BASE = 18'h00200;
   localparam logic [17:0] FC1_W_BASE   = 18'h05000;
   localparam logic [17:0] FC2_W_BASE   = 18'h3F000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority search starting at a pointer
// Purpose : find the first asserted request at or after ptr, wrapping at NUM_REQ-1.
// Ports   : req    in  NUM_REQ  request mask
//           ptr    in  IDX_W    index with highest priority
//           onehot out NUM_REQ  one-hot of the selected request (0 if none)
//           idx    out IDX_W    index of the selected request (0 if none)
//           any    out 1        a request was selected
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int w_pos;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      w_pos  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = int'(ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (!any && req[IDX_W'(w_pos)]) begin
            any                   = 1'b1;
            onehot[IDX_W'(w_pos)] = 1'b1;
            idx                   = IDX_W'(w_pos);
         end
      end
   end

endmodule

// File: rtl/weight_port_arbiter.sv
// rtl/weight_port_arbiter.sv - round-robin, burst-locking arbiter for the shared weight memory read port
// Purpose : grants one requester beat per cycle onto mem_en/mem_addr, locks to an owner for
//           multi-beat bursts, and routes read data back after a fixed MEM_LAT latency.
// Ports   : clk, reset (async, active-high)
//           req/req_addr/req_last  in   per-requester read beats
//           gnt                    out  one-hot grant, same cycle as the beat
//           mem_en/mem_addr        out  memory read command
//           mem_rdata              in   memory data, MEM_LAT cycles after mem_en
//           rsp_valid/rsp_data     out  one-hot response strobe and shared data bus
//           gnt_cnt/stall_cnt      out  saturating per-requester counters (ARB_PERF_CNT_EN only)
// Config  : define ARB_PERF_CNT_EN to add the performance counters.
module weight_port_arbiter
   import cnn_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ*32-1:0]     gnt_cnt,
   output logic [NUM_REQ*32-1:0]     stall_cnt
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [IDX_W-1:0]        w_rr_ptr_nxt;
   logic [IDX_W-1:0]        r_owner;
   logic [IDX_W-1:0]        w_owner_nxt;
   logic [NUM_REQ-1:0]      w_pick_oh;
   logic [IDX_W-1:0]        w_pick_idx;
   logic                    w_pick_any;
   logic [IDX_W-1:0]        w_gnt_idx;

   logic [MEM_LAT-1:0]            r_tag_v;
   logic [MEM_LAT-1:0][IDX_W-1:0] r_tag_idx;

   function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (r_rr_ptr),
      .onehot (w_pick_oh),
      .idx    (w_pick_idx),
      .any    (w_pick_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ARB_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_owner  <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_owner_nxt  = r_owner;
      gnt          = '0;
      w_gnt_idx    = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               gnt       = w_pick_oh;
               w_gnt_idx = w_pick_idx;
               if (req_last[w_pick_idx]) begin
                  w_rr_ptr_nxt = f_next(w_pick_idx);
               end else begin
                  w_state_nxt = ARB_LOCKED;
                  w_owner_nxt = w_pick_idx;
               end
            end
         end
         ARB_LOCKED: begin
            // Owner dropping req ends the burst early; nobody is granted that cycle.
            if (req[r_owner]) begin
               gnt[r_owner] = 1'b1;
               w_gnt_idx    = r_owner;
               if (req_last[r_owner]) begin
                  w_state_nxt  = ARB_IDLE;
                  w_rr_ptr_nxt = f_next(r_owner);
               end
            end else begin
               w_state_nxt  = ARB_IDLE;
               w_rr_ptr_nxt = f_next(r_owner);
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign mem_en   = |gnt;
   assign mem_addr = mem_en ? req_addr[w_gnt_idx*ADDR_W +: ADDR_W] : '0;

   // Tag shift register: stage MEM_LAT-1 lines up with mem_rdata for the beat issued
   // MEM_LAT cycles earlier; reset empties it so in-flight beats never respond.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_v   <= '0;
         r_tag_idx <= '0;
      end else begin
         r_tag_v[0]   <= mem_en;
         r_tag_idx[0] <= w_gnt_idx;
         for (int k = 1; k < MEM_LAT; k++) begin
            r_tag_v[k]   <= r_tag_v[k-1];
            r_tag_idx[k] <= r_tag_idx[k-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (r_tag_v[MEM_LAT-1]) begin
         rsp_valid[r_tag_idx[MEM_LAT-1]] = 1'b1;
         rsp_data                        = mem_rdata;
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (gnt_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
               gnt_cnt[i*32 +: 32] <= gnt_cnt[i*32 +: 32] + 32'd1;
            end
            if (req[i] && !gnt[i] && (stall_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
               stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: doc/weight_port_arbiter.md
WEIGHT_PORT_ARBITER -- requirements
Module: weight_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (0=conv1, 1=conv2, 2=fc1, 3=fc2).
REQ-002 Parameter ADDR_W, default 18, SHALL set the width of the flat weight/bias address.
REQ-003 Parameter DATA_W, default 8, SHALL set the memory read data width.
REQ-004 Parameter MEM_LAT, default 1, range 1-4, SHALL set the fixed memory read latency in cycles.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester read request, held until granted.
REQ-008 req_addr  input  NUM_REQ x ADDR_W  per-requester read address.
REQ-009 req_last  input  NUM_REQ  marks the final beat of a requester's burst.
REQ-010 gnt  output  NUM_REQ  one-hot grant, combinational in the cycle the beat is issued.
REQ-011 mem_en  output  1  memory read enable.
REQ-012 mem_addr  output  ADDR_W  memory read address.
REQ-013 mem_rdata  input  DATA_W  memory data, valid MEM_LAT cycles after mem_en.
REQ-014 rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-015 rsp_data  output  DATA_W  response data, shared bus.

Function
REQ-016 The arbiter SHALL use the two states IDLE (no owner) and LOCKED (owner register valid).
- IDLE: grant the first asserted req at or after rr_ptr, scanning upward with wrap from NUM_REQ-1 to 0.
- IDLE -> LOCKED when the granted beat has req_last=0.
REQ-017 In LOCKED, only the owner SHALL be granted, and it SHALL be granted every cycle its req is high; all other requests stall.
REQ-018 LOCKED -> IDLE on an owner beat with req_last=1, or when the owner drops req; in both cases rr_ptr becomes owner+1 mod NUM_REQ.
REQ-019 A single-beat grant from IDLE with req_last=1 SHALL stay in IDLE and set rr_ptr to the granted index+1 mod NUM_REQ.
REQ-020 At most one gnt bit SHALL be high per cycle; mem_en=|gnt; mem_addr=req_addr of the granted index, else 0.
REQ-021 A tag pipeline MEM_LAT deep SHALL carry {valid, index} per issued beat, giving one response per cycle with no bubbles.
REQ-022 rsp_valid[i] SHALL rise exactly MEM_LAT cycles after gnt[i]; rsp_data=mem_rdata in that cycle, else 0.
REQ-023 Responses SHALL return in issue order; the block SHALL NOT back-pressure responses.
REQ-024 A requester with req=0 SHALL never be granted.
REQ-025 When no request is present, gnt=0 and mem_en=0.

Reset
REQ-026 On reset, all of the following SHALL clear asynchronously: state=IDLE, rr_ptr=0, owner=0, tag pipeline empty, rsp_valid=0, rsp_data=0.
REQ-027 Beats in flight at reset SHALL be discarded; no rsp_valid SHALL appear for them after reset deasserts.

Configuration
REQ-028 With ARB_PERF_CNT_EN defined, the block SHALL add the following outputs, both saturating at all-ones and cleared by reset:
- gnt_cnt (NUM_REQ x 32): counts beats granted per requester.
- stall_cnt (NUM_REQ x 32): counts cycles with req high and gnt low per requester.
REQ-029 Without ARB_PERF_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package cnn_pkg SHALL hold:
- the requester index enum (REQ_CONV1, REQ_CONV2, REQ_FC1, REQ_FC2);
- the arbiter state typedef;
- the address-map base constants (CONV1_W_BASE, CONV2_W_BASE, FC1_W_BASE, FC2_W_BASE).
REQ-031 The round-robin priority search SHALL be one sub-module, rr_pick (inputs req mask and pointer; outputs one-hot and index); the tag pipeline SHALL stay inline.

Verification
REQ-032 Single beat: reset, req[2]=1, req_last[2]=1, addr=0x100 with MEM_LAT=1 -> gnt[2] in the same cycle, mem_addr=0x100, rsp_valid[2] one cycle later, rr_ptr=3.
REQ-033 Fairness: req=4'b1111, all req_last=1, held 8 cycles -> grant order 0,1,2,3,0,1,2,3 with zero idle cycles.
REQ-034 Burst lock:
- Stimulus: req[1] makes a 5-beat burst (last on beat 5) while req[0] and req[3] are held high.
- Response: gnt[1] for 5 consecutive cycles, then gnt[3] next, then gnt[0].
REQ-035 Owner drop: owner 0 drops req mid-burst after 2 beats while req[2] is high -> IDLE, rr_ptr=1, gnt[2] in the cycle after the drop.
REQ-036 Reset in flight:
- Stimulus: MEM_LAT=3, issue 3 beats, assert reset on the cycle after the 3rd beat.
- Response: rsp_valid stays 0 for 5 cycles after reset deasserts with req=0.
REQ-037 Perf counters: with ARB_PERF_CNT_EN, req[0] and req[1] both high for 10 single-beat cycles -> gnt_cnt[0]=5, gnt_cnt[1]=5, stall_cnt[0]=5, stall_cnt[1]=5.
